port_rr_scheduler: RTL and testbench

//   Round-robin scheduler that shares one downstream consumer (monitor/checker channel)

---
 rtl/sched_pkg.sv | 19 +
 rtl/rr_pick.sv | 46 ++++
 rtl/port_rr_scheduler.sv | 117 +++++++++++
 tb/tb_port_rr_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sched_pkg : shared types and helpers for the round-robin port scheduler    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // Index width for n ports, never narrower than one bit.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first request at or after ptr  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick #(
    parameter int N  = 6,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    localparam int c_DW = 2 * N;
    localparam int c_CW = $clog2(c_DW);

    logic [c_DW-1:0] w_dbl;
    logic [c_DW-1:0] w_mask;
    logic [c_DW-1:0] w_sel;
    logic [c_CW-1:0] w_pos;

    // The upper copy is never masked, so the scan wraps past N-1 back to 0.
    always_comb begin
        w_dbl = {req_i, req_i};
        for (int i = 0; i < c_DW; i++) begin
            w_mask[i] = (i >= int'(ptr_i));
        end
        w_sel   = w_dbl & w_mask;
        found_o = |req_i;
        w_pos   = '0;
        for (int i = c_DW - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_pos = c_CW'(i);
            end
        end
        if (w_pos >= c_CW'(N)) begin
            idx_o = PW'(w_pos - c_CW'(N));
        end else begin
            idx_o = PW'(w_pos);
        end
    end

endmodule
`default_nettype wire

// File: rtl/port_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | port_rr_scheduler : shares one consumer among PORT_COUNT valid/ready ports |
// | with burst-locked round-robin grants.  Rev 1.0                             |
// +----------------------------------------------------------------------------+
module port_rr_scheduler
    import sched_pkg::*;
#(
    parameter int PORT_COUNT = 6,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_COUNT-1:0]          req_valid,
    input  logic [PORT_COUNT*DATA_W-1:0]   req_data,
    input  logic [PORT_COUNT-1:0]          req_last,
    output logic [PORT_COUNT-1:0]          req_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic [port_w(PORT_COUNT)-1:0]  out_port,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int c_PORT_W = port_w(PORT_COUNT);
    localparam int c_CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_PORT_W-1:0] c_PORT_MAX = c_PORT_W'(PORT_COUNT - 1);

    sched_state_e          state_q;
    logic [c_PORT_W-1:0]   ptr_q;
    logic [c_PORT_W-1:0]   owner_q;
    logic [c_CNT_W-1:0]    cnt_q;

    logic [c_PORT_W-1:0]   w_pick_idx;
    logic                  w_pick_found;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [DATA_W-1:0]     w_own_data;
    logic                  w_locked;
    logic                  w_accept;

    rr_pick #(
        .N  (PORT_COUNT),
        .PW (c_PORT_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (w_pick_idx),
        .found_o (w_pick_found)
    );

    // Explicit compare mux keeps unused owner encodings from indexing out of range.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (owner_q == c_PORT_W'(i)) begin
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                w_own_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_locked = (state_q == LOCKED);

    always_comb begin
        out_valid = w_locked && w_own_valid;
        out_data  = out_valid ? w_own_data : '0;
        out_last  = out_valid && (w_own_last || (cnt_q == c_CNT_LAST));
        out_port  = w_locked ? owner_q : '0;
        busy      = w_locked;
        req_ready = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            req_ready[i] = w_locked && out_ready && (owner_q == c_PORT_W'(i));
        end
    end

    assign w_accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pick_found) begin
                        owner_q <= w_pick_idx;
                        cnt_q   <= '0;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_accept) begin
                        if (out_last) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            ptr_q   <= (owner_q == c_PORT_MAX) ? '0 : owner_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_port_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_port_rr_scheduler : scoreboard bench with packet-level port sources     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_port_rr_scheduler;

    localparam int NP   = 6;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [2:0]    port;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_valid = '0;
    logic [NP*DW-1:0]  req_data  = '0;
    logic [NP-1:0]     req_last  = '0;
    logic [NP-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [2:0]        out_port;
    logic              out_ready = 1'b0;
    logic              busy;

    port_rr_scheduler #(
        .PORT_COUNT (NP),
        .DATA_W     (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_port  (out_port),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Sources: each port holds a queue of pending beats {last, data}.
    logic [DW:0]   src_q [NP][$];
    logic [NP-1:0] vld = '0;
    logic [NP-1:0] acc = '0;
    int            acc_cnt [NP];
    bit            rand_mode = 1'b0;

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: grant-level view of the scheduler.
    bit m_locked = 1'b0;
    bit m_fresh  = 1'b1;
    int m_ptr    = 0;
    int m_owner  = 0;
    int m_n      = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int p, input int len, input int dsel);
        logic [DW:0] b;
        for (int k = 0; k < len; k++) begin
            b[DW-1:0] = (dsel < 0) ? DW'($urandom_range(0, 255)) : DW'(dsel);
            b[DW]     = (k == len - 1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic tick();
        logic [DW:0] b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                vld[i] = 1'b0;
                acc[i] = 1'b0;
                acc_cnt[i]++;
            end
            if (!vld[i] && src_q[i].size() > 0)
                vld[i] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            b = vld[i] ? src_q[i][0] : '0;
            req_data[i*DW +: DW] = b[DW-1:0];
            req_last[i]          = vld[i] & b[DW];
        end
        req_valid = vld;
    endtask

    function automatic bit pending();
        bit p = m_locked;
        for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        while (pending() && n < 2000) begin
            tick();
            n++;
        end
        check(nm, int'(pending()), 0);
    endtask

    task automatic wait_acc(input string nm, input int p, input int target);
        int n = 0;
        while (acc_cnt[p] < target && n < 200) begin
            tick();
            n++;
        end
        check(nm, acc_cnt[p], target);
    endtask

    // Model step: per-cycle expectations, beat prediction, then grant update.
    initial begin
        logic [DW:0] hd;
        bit          e_valid, e_acc, e_last;
        int          e_rr;
        bit          found;
        forever begin
            @(negedge clk);
            e_valid = m_locked && vld[m_owner];
            e_rr    = (m_locked && out_ready) ? (1 << m_owner) : 0;
            check("busy", int'(busy), int'(m_locked));
            check("out_valid", int'(out_valid), int'(e_valid));
            check("req_ready", int'(req_ready), e_rr);
            if (m_locked || m_fresh)
                check("out_port", int'(out_port), m_locked ? m_owner : 0);
            e_acc = e_valid && out_ready && !rst;
            e_last = 1'b0;
            if (e_acc) begin
                hd     = src_q[m_owner][0];
                e_last = hd[DW] || (m_n == MAXB - 1);
                exp_q.push_back('{port: 3'(m_owner), data: hd[DW-1:0], last: e_last});
            end
            if (rst) begin
                m_locked = 1'b0;
                m_fresh  = 1'b1;
                m_ptr    = 0;
                m_owner  = 0;
                m_n      = 0;
            end else if (!m_locked) begin
                found = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    if (!found && vld[(m_ptr + k) % NP]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % NP;
                    end
                end
                if (found) begin
                    m_locked = 1'b1;
                    m_fresh  = 1'b0;
                    m_n      = 0;
                end
            end else if (e_acc) begin
                if (e_last) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % NP;
                    m_n      = 0;
                end else begin
                    m_n++;
                end
            end
        end
    end

    // Monitor: records source handshakes and scores every accepted beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NP; i++) acc[i] = vld[i] && req_ready[i];
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_port", int'(out_port), int'(e.port));
                    check("beat_data", int'(out_data), int'(e.data));
                    check("beat_last", int'(out_last), int'(e.last));
                end
            end else if (!out_valid) begin
                check("idle_data", int'(out_data), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < NP; i++) acc_cnt[i] = 0;

        // Reset held with every port requesting, then one-beat packets rotate 0..5,0.
        for (int p = 0; p < NP; p++) add_pkt(p, 1, p);
        add_pkt(0, 1, 0);
        repeat (3) tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        drain("drain_rotate");

        // Single port, 10 beats: grants of 4, 4, 2.
        add_pkt(3, 10, -1);
        drain("drain_burst_split");

        // Port 5 wraps ptr to 0, so port 2 wins over port 4.
        add_pkt(5, 1, -1);
        drain("drain_wrap");
        add_pkt(4, 2, -1);
        add_pkt(2, 2, -1);
        drain("drain_after_wrap");

        // Consumer stall mid-burst.
        base = acc_cnt[1];
        add_pkt(1, 6, -1);
        wait_acc("wait_port1_beat2", 1, base + 2);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        drain("drain_stall");

        // Reset during beat 2 of a port 4 burst; port 0 then wins.
        base = acc_cnt[4];
        add_pkt(4, 4, -1);
        wait_acc("wait_port4_beat1", 4, base + 1);
        add_pkt(0, 1, -1);
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        drain("drain_reset_abort");

        // Random traffic with source gaps and consumer back-pressure.
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = int'($urandom_range(0, NP - 1));
                if (src_q[p].size() < 12) add_pkt(p, int'($urandom_range(1, 6)), -1);
            end
            tick();
        end
        out_ready = 1'b1;
        drain("drain_random");
        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
